// File: rtl/ex_mem_elastic_reg_if.sv
// EX/MEM handshake, payload and writeback-forward bundle for ex_mem_elastic_reg.
// The slave modport is the register's view; master is the EX/MEM environment's view.
interface ex_mem_elastic_reg_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int REG_BITS     = 5
);
    localparam int BE_W = DATA_WIDTH / 8;

    logic                    flush;
    logic                    ex_valid;
    logic                    ex_ready;
    logic                    ex_memRead;
    logic                    ex_memWrite;
    logic                    ex_regWrite;
    logic [DATA_WIDTH-1:0]   ex_ALU_result;
    logic [DATA_WIDTH-1:0]   ex_rs2_data;
    logic [BE_W-1:0]         ex_byte_en;
    logic [REG_BITS-1:0]     ex_rd;

    logic                    mem_valid;
    logic                    mem_ready;
    logic                    mem_load;
    logic                    mem_store;
    logic                    mem_regWrite;
    logic [DATA_WIDTH-1:0]   mem_ALU_result;
    logic [ADDRESS_BITS-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]   mem_store_data;
    logic [BE_W-1:0]         mem_byte_en;
    logic [REG_BITS-1:0]     mem_rd;

    logic                    mem_write;
    logic [REG_BITS-1:0]     mem_write_reg;
    logic [DATA_WIDTH-1:0]   mem_write_data;
    logic                    ex_write;
    logic [REG_BITS-1:0]     ex_write_reg;
    logic [DATA_WIDTH-1:0]   ex_write_data;

    modport slave (
        input  flush, ex_valid, ex_memRead, ex_memWrite, ex_regWrite,
               ex_ALU_result, ex_rs2_data, ex_byte_en, ex_rd,
               mem_ready, mem_write, mem_write_reg, mem_write_data,
        output ex_ready, mem_valid, mem_load, mem_store, mem_regWrite,
               mem_ALU_result, mem_addr, mem_store_data, mem_byte_en, mem_rd,
               ex_write, ex_write_reg, ex_write_data
    );

    modport master (
        output flush, ex_valid, ex_memRead, ex_memWrite, ex_regWrite,
               ex_ALU_result, ex_rs2_data, ex_byte_en, ex_rd,
               mem_ready, mem_write, mem_write_reg, mem_write_data,
        input  ex_ready, mem_valid, mem_load, mem_store, mem_regWrite,
               mem_ALU_result, mem_addr, mem_store_data, mem_byte_en, mem_rd,
               ex_write, ex_write_reg, ex_write_data
    );
endinterface

// File: rtl/ex_mem_elastic_reg.sv
// EX/MEM elastic pipeline register with valid/ready, flush and a one-cycle writeback-forward path.
// Define EX_MEM_SKID_EN for a registered ex_ready backed by a second (skid) entry.
//
// state | meaning
// EMPTY | no valid entry
// FULL  | main entry valid
// SKID  | main and skid entries valid (EX_MEM_SKID_EN only)
module ex_mem_elastic_reg #(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int REG_BITS     = 5
) (
    input logic                   clock,
    input logic                   reset,
    ex_mem_elastic_reg_if.slave   bus
);
    localparam int BE_W = DATA_WIDTH / 8;

    if (CORE < 0 || (DATA_WIDTH % 8) != 0) begin : g_bad_params
        $error("ex_mem_elastic_reg: CORE must be >= 0 and DATA_WIDTH a multiple of 8");
    end

    typedef struct packed {
        logic                  ld;
        logic                  st;
        logic                  rw;
        logic [DATA_WIDTH-1:0] alu;
        logic [DATA_WIDTH-1:0] rs2;
        logic [BE_W-1:0]       be;
        logic [REG_BITS-1:0]   rd;
    } entry_t;

`ifdef EX_MEM_SKID_EN
    typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;
`else
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
`endif

    state_t                state_q, state_d;
    entry_t                main_q, main_d;
    entry_t                in_entry;
    logic                  mem_valid;
    logic                  ex_ready;
    logic                  accept;
    logic                  consume;
    logic                  ex_write_q;
    logic [REG_BITS-1:0]   ex_write_reg_q;
    logic [DATA_WIDTH-1:0] ex_write_data_q;
`ifdef EX_MEM_SKID_EN
    entry_t                skid_q, skid_d;
`endif

    assign in_entry = '{ld:  bus.ex_memRead,
                        st:  bus.ex_memWrite,
                        rw:  bus.ex_regWrite,
                        alu: bus.ex_ALU_result,
                        rs2: bus.ex_rs2_data,
                        be:  bus.ex_byte_en,
                        rd:  bus.ex_rd};

    assign mem_valid = (state_q != EMPTY);
`ifdef EX_MEM_SKID_EN
    // Registered ready: depends only on whether the skid slot is occupied.
    assign ex_ready  = (state_q != SKID);
`else
    assign ex_ready  = !mem_valid || bus.mem_ready;
`endif
    assign accept    = bus.ex_valid && ex_ready;
    assign consume   = mem_valid && bus.mem_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef EX_MEM_SKID_EN
        skid_d  = skid_q;
`endif
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                    main_d  = in_entry;
                end
            end
            FULL: begin
                if (accept && consume) begin
                    main_d = in_entry;
                end else if (consume) begin
                    state_d = EMPTY;
`ifdef EX_MEM_SKID_EN
                end else if (accept) begin
                    state_d = SKID;
                    skid_d  = in_entry;
`endif
                end
            end
`ifdef EX_MEM_SKID_EN
            SKID: begin
                if (consume) begin
                    state_d = FULL;
                    main_d  = skid_q;
                end
            end
`endif
            default: state_d = EMPTY;
        endcase
        // Flush drops a same-cycle accept entirely, so held data stays untouched too.
        if (bus.flush) begin
            state_d = EMPTY;
            main_d  = main_q;
`ifdef EX_MEM_SKID_EN
            skid_d  = skid_q;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= EMPTY;
            main_q          <= '0;
`ifdef EX_MEM_SKID_EN
            skid_q          <= '0;
`endif
            ex_write_q      <= 1'b0;
            ex_write_reg_q  <= '0;
            ex_write_data_q <= '0;
        end else begin
            state_q         <= state_d;
            main_q          <= main_d;
`ifdef EX_MEM_SKID_EN
            skid_q          <= skid_d;
`endif
            ex_write_q      <= bus.mem_write;
            ex_write_reg_q  <= bus.mem_write_reg;
            ex_write_data_q <= bus.mem_write_data;
        end
    end

    assign bus.ex_ready       = ex_ready;
    assign bus.mem_valid      = mem_valid;
    assign bus.mem_load       = mem_valid & main_q.ld;
    assign bus.mem_store      = mem_valid & main_q.st;
    assign bus.mem_regWrite   = mem_valid & main_q.rw & (|main_q.rd);
    assign bus.mem_ALU_result = main_q.alu;
    assign bus.mem_addr       = main_q.alu[ADDRESS_BITS-1:0];
    assign bus.mem_store_data = main_q.rs2;
    assign bus.mem_byte_en    = main_q.be;
    assign bus.mem_rd         = main_q.rd;
    assign bus.ex_write       = ex_write_q;
    assign bus.ex_write_reg   = ex_write_reg_q;
    assign bus.ex_write_data  = ex_write_data_q;
endmodule

// File: tb/tb_ex_mem_elastic_reg.sv
// Directed, table-driven bench for ex_mem_elastic_reg (default and EX_MEM_SKID_EN builds).
module tb_ex_mem_elastic_reg;
    logic clock;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    ex_mem_elastic_reg_if #(.DATA_WIDTH(32), .ADDRESS_BITS(20), .REG_BITS(5)) bus ();

    ex_mem_elastic_reg #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20), .REG_BITS(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        fl, ev, mr;
        logic [31:0] alu;
        logic        ld, st, rw;
        logic [4:0]  rd;
        logic        e_rdy, e_vld;
        logic [31:0] e_alu;
        logic        e_ld, e_st, e_rw;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t tv[14];

    function automatic vec_t mk(input logic fl, ev, mr, input logic [31:0] alu,
                                input logic ld, st, rw, input logic [4:0] rd,
                                input logic e_rdy, e_vld, input logic [31:0] e_alu,
                                input logic e_ld, e_st, e_rw, input logic [4:0] e_rd);
        vec_t v;
        v.fl = fl; v.ev = ev; v.mr = mr; v.alu = alu;
        v.ld = ld; v.st = st; v.rw = rw; v.rd = rd;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_alu = e_alu;
        v.e_ld = e_ld; v.e_st = e_st; v.e_rw = e_rw; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, ev, mr, input logic [31:0] alu, rs2,
                         input logic [3:0] be, input logic ld, st, rw, input logic [4:0] rd);
        bus.flush         = fl;
        bus.ex_valid      = ev;
        bus.mem_ready     = mr;
        bus.ex_ALU_result = alu;
        bus.ex_rs2_data   = rs2;
        bus.ex_byte_en    = be;
        bus.ex_memRead    = ld;
        bus.ex_memWrite   = st;
        bus.ex_regWrite   = rw;
        bus.ex_rd         = rd;
    endtask

    initial begin
        // ---------------- vector table (inputs | ready before edge, outputs after edge)
        tv[0]  = mk(0,1,1,32'h10,1,0,1,5'd3,  1,1,32'h10,1,0,1,5'd3);
        tv[1]  = mk(0,1,1,32'h14,0,1,1,5'd0,  1,1,32'h14,0,1,0,5'd0);
        tv[2]  = mk(0,1,1,32'h18,0,0,1,5'd5,  1,1,32'h18,0,0,1,5'd5);
`ifdef EX_MEM_SKID_EN
        tv[3]  = mk(0,0,0,32'h0 ,0,0,0,5'd0,  1,1,32'h18,0,0,1,5'd5);
        tv[4]  = mk(0,1,0,32'h20,0,0,0,5'd0,  1,1,32'h18,0,0,1,5'd5);
        tv[5]  = mk(0,0,1,32'h0 ,0,0,0,5'd0,  0,1,32'h20,0,0,0,5'd0);
        tv[6]  = mk(1,1,0,32'h24,1,0,0,5'd0,  1,0,32'h20,0,0,0,5'd0);
        tv[7]  = mk(0,1,0,32'h28,1,0,0,5'd2,  1,1,32'h28,1,0,0,5'd2);
        tv[8]  = mk(1,1,0,32'h2C,0,0,0,5'd0,  1,0,32'h28,0,0,0,5'd2);
        tv[9]  = mk(0,0,0,32'h0 ,0,0,0,5'd0,  1,0,32'h28,0,0,0,5'd2);
        tv[10] = mk(0,1,0,32'h30,0,0,1,5'd1,  1,1,32'h30,0,0,1,5'd1);
        tv[11] = mk(0,1,0,32'h34,0,0,0,5'd0,  1,1,32'h30,0,0,1,5'd1);
        tv[12] = mk(1,1,0,32'h38,0,0,0,5'd0,  0,0,32'h30,0,0,0,5'd1);
        tv[13] = mk(0,0,0,32'h0 ,0,0,0,5'd0,  1,0,32'h30,0,0,0,5'd1);
`else
        tv[3]  = mk(0,0,0,32'h0 ,0,0,0,5'd0,  0,1,32'h18,0,0,1,5'd5);
        tv[4]  = mk(0,1,0,32'h20,0,0,0,5'd0,  0,1,32'h18,0,0,1,5'd5);
        tv[5]  = mk(0,0,1,32'h0 ,0,0,0,5'd0,  1,0,32'h18,0,0,0,5'd5);
        tv[6]  = mk(1,1,0,32'h24,1,0,0,5'd0,  1,0,32'h18,0,0,0,5'd5);
        tv[7]  = mk(0,1,0,32'h28,1,0,0,5'd2,  1,1,32'h28,1,0,0,5'd2);
        tv[8]  = mk(1,1,0,32'h2C,0,0,0,5'd0,  0,0,32'h28,0,0,0,5'd2);
        tv[9]  = mk(0,0,0,32'h0 ,0,0,0,5'd0,  1,0,32'h28,0,0,0,5'd2);
        tv[10] = mk(0,1,0,32'h30,0,0,1,5'd1,  1,1,32'h30,0,0,1,5'd1);
        tv[11] = mk(0,1,0,32'h34,0,0,0,5'd0,  0,1,32'h30,0,0,1,5'd1);
        tv[12] = mk(1,1,0,32'h38,0,0,0,5'd0,  0,0,32'h30,0,0,0,5'd1);
        tv[13] = mk(0,0,0,32'h0 ,0,0,0,5'd0,  1,0,32'h30,0,0,0,5'd1);
`endif

        // ---------------- reset: held 3 cycles with traffic and flush present
        reset = 1'b0;
        drive(1, 1, 1, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 4'hF, 1, 1, 1, 5'd3);
        bus.mem_write      = 1'b1;
        bus.mem_write_reg  = 5'd7;
        bus.mem_write_data = 32'h1234_5678;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst mem_valid",      64'(bus.mem_valid), 0);
        chk("rst mem_load",       64'(bus.mem_load), 0);
        chk("rst mem_store",      64'(bus.mem_store), 0);
        chk("rst mem_regWrite",   64'(bus.mem_regWrite), 0);
        chk("rst mem_ALU_result", 64'(bus.mem_ALU_result), 0);
        chk("rst mem_store_data", 64'(bus.mem_store_data), 0);
        chk("rst mem_byte_en",    64'(bus.mem_byte_en), 0);
        chk("rst mem_rd",         64'(bus.mem_rd), 0);
        chk("rst ex_write",       64'(bus.ex_write), 0);
        chk("rst ex_write_data",  64'(bus.ex_write_data), 0);
        drive(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 5'd0);
        bus.mem_write      = 1'b0;
        bus.mem_write_reg  = 5'd0;
        bus.mem_write_data = 32'h0;
        reset = 1'b1;
        #1 chk("rel ex_ready", 64'(bus.ex_ready), 1);
        @(posedge clock);
        #1 chk("rel mem_valid", 64'(bus.mem_valid), 0);

        // ---------------- table: streaming, stall, rd zero, flush collisions
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            drive(tv[i].fl, tv[i].ev, tv[i].mr, tv[i].alu, ~tv[i].alu, tv[i].alu[3:0],
                  tv[i].ld, tv[i].st, tv[i].rw, tv[i].rd);
            #1 chk($sformatf("v%0d ex_ready", i), 64'(bus.ex_ready), 64'(tv[i].e_rdy));
            @(posedge clock);
            #1;
            chk($sformatf("v%0d mem_valid", i),    64'(bus.mem_valid),      64'(tv[i].e_vld));
            chk($sformatf("v%0d mem_ALU", i),      64'(bus.mem_ALU_result), 64'(tv[i].e_alu));
            chk($sformatf("v%0d mem_load", i),     64'(bus.mem_load),       64'(tv[i].e_ld));
            chk($sformatf("v%0d mem_store", i),    64'(bus.mem_store),      64'(tv[i].e_st));
            chk($sformatf("v%0d mem_regWrite", i), 64'(bus.mem_regWrite),   64'(tv[i].e_rw));
            chk($sformatf("v%0d mem_rd", i),       64'(bus.mem_rd),         64'(tv[i].e_rd));
        end

        // ---------------- stall: store held for 4 cycles; second offer goes to skid if present
        @(negedge clock);
        drive(0, 1, 0, 32'h1234_5678, 32'hDEAD_BEEF, 4'b0011, 0, 1, 0, 5'd9);
        @(posedge clock);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            drive(0, (i == 0), 0, 32'hCAFE_0000, 32'h0BAD_F00D, 4'b1100, 1, 0, 1, 5'd4);
`ifdef EX_MEM_SKID_EN
            #1 chk($sformatf("stall%0d ex_ready", i), 64'(bus.ex_ready), (i == 0) ? 64'd1 : 64'd0);
`else
            #1 chk($sformatf("stall%0d ex_ready", i), 64'(bus.ex_ready), 0);
`endif
            @(posedge clock);
            #1;
            chk($sformatf("stall%0d mem_valid", i),  64'(bus.mem_valid),      1);
            chk($sformatf("stall%0d mem_store", i),  64'(bus.mem_store),      1);
            chk($sformatf("stall%0d mem_load", i),   64'(bus.mem_load),       0);
            chk($sformatf("stall%0d mem_ALU", i),    64'(bus.mem_ALU_result), 64'h1234_5678);
            chk($sformatf("stall%0d mem_addr", i),   64'(bus.mem_addr),       64'h4_5678);
            chk($sformatf("stall%0d store_data", i), 64'(bus.mem_store_data), 64'hDEAD_BEEF);
            chk($sformatf("stall%0d byte_en", i),    64'(bus.mem_byte_en),    64'h3);
            chk($sformatf("stall%0d mem_rd", i),     64'(bus.mem_rd),         9);
        end
        @(negedge clock);
        drive(0, 0, 1, 32'h0, 32'h0, 4'h0, 0, 0, 0, 5'd0);
        @(posedge clock);
        #1;
`ifdef EX_MEM_SKID_EN
        chk("drain mem_valid",  64'(bus.mem_valid),      1);
        chk("drain mem_ALU",    64'(bus.mem_ALU_result), 64'hCAFE_0000);
        chk("drain mem_load",   64'(bus.mem_load),       1);
        chk("drain regWrite",   64'(bus.mem_regWrite),   1);
        chk("drain ex_ready",   64'(bus.ex_ready),       1);
        @(posedge clock);
        #1 chk("drain2 mem_valid", 64'(bus.mem_valid), 0);
`else
        chk("drain mem_valid",  64'(bus.mem_valid),      0);
        chk("drain mem_store",  64'(bus.mem_store),      0);
        chk("drain store_data", 64'(bus.mem_store_data), 64'hDEAD_BEEF);
`endif

        // ---------------- forwarding path ignores stall and flush
        @(negedge clock);
        drive(0, 1, 0, 32'h40, 32'h0, 4'h0, 1, 0, 0, 5'd0);
        @(posedge clock);
        @(negedge clock);
        drive(1, 1, 0, 32'h44, 32'h0, 4'h0, 0, 1, 0, 5'd0);
        bus.mem_write      = 1'b1;
        bus.mem_write_reg  = 5'd7;
        bus.mem_write_data = 32'h55;
        @(posedge clock);
        #1;
        chk("fwd ex_write",      64'(bus.ex_write),      1);
        chk("fwd ex_write_reg",  64'(bus.ex_write_reg),  7);
        chk("fwd ex_write_data", 64'(bus.ex_write_data), 64'h55);
        chk("fwd mem_valid",     64'(bus.mem_valid),     0);
        chk("fwd mem_load",      64'(bus.mem_load),      0);
        chk("fwd ex_ready",      64'(bus.ex_ready),      1);
        @(negedge clock);
        drive(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 5'd0);
        bus.mem_write      = 1'b0;
        bus.mem_write_reg  = 5'd2;
        bus.mem_write_data = 32'hAA;
        @(posedge clock);
        #1;
        chk("fwd2 ex_write",      64'(bus.ex_write),      0);
        chk("fwd2 ex_write_reg",  64'(bus.ex_write_reg),  2);
        chk("fwd2 ex_write_data", 64'(bus.ex_write_data), 64'hAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
